// File: rtl/paramest_dense_acc_pkg.sv
// paramest_acc_pkg: shared types and constant helpers for the ParamEst dense
// accumulator and its round/saturate stage.
package paramest_acc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        BIAS,
        OUT
    } state_t;

    // Accumulator width: product magnitude, growth for N_IN terms, sign and bias headroom.
    function automatic int acc_width(input int n_in, input int prod_w);
        return prod_w + $clog2(n_in) + 2;
    endfunction

    function automatic longint sat_max(input int out_w);
        return (longint'(1) <<< (out_w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int out_w);
        return -(longint'(1) <<< (out_w - 1));
    endfunction

endpackage

// File: rtl/paramest_dense_acc_if.sv
// paramest_dense_acc_if: product input stream, neuron bias and result output
// stream of the dense accumulator. slave = accumulator side, master = environment.
interface paramest_dense_acc_if #(
    parameter int PROD_W = 29,
    parameter int BIAS_W = 24,
    parameter int OUT_W  = 16
);
    logic              prod_valid;
    logic              prod_ready;
    logic [PROD_W-1:0] prod_data;
    logic              prod_neg;
    logic [BIAS_W-1:0] bias;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_ovf;

    modport slave (
        input  prod_valid, prod_data, prod_neg, bias, out_ready,
        output prod_ready, out_valid, out_data, out_ovf
    );

    modport master (
        output prod_valid, prod_data, prod_neg, bias, out_ready,
        input  prod_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/paramest_dense_acc_round_sat.sv
// paramest_round_sat: combinational rescale of an accumulator-scale sum by
// FRAC_SHIFT (round half toward +inf) followed by signed saturation to OUT_W.
module paramest_round_sat
    import paramest_acc_pkg::*;
#(
    parameter int ACC_W      = 35,
    parameter int OUT_W      = 16,
    parameter int FRAC_SHIFT = 13
) (
    input  logic signed [ACC_W-1:0] sum,
    output logic signed [OUT_W-1:0] res,
    output logic                    ovf
);
    localparam logic signed [ACC_W:0] MAXV = (ACC_W + 1)'(sat_max(OUT_W));
    localparam logic signed [ACC_W:0] MINV = (ACC_W + 1)'(sat_min(OUT_W));

    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] rnd;

    // One extra bit so adding the rounding constant cannot overflow.
    assign ext = {sum[ACC_W-1], sum};

    if (FRAC_SHIFT == 0) begin : g_noround
        assign rnd = ext;
    end else begin : g_round
        localparam logic signed [ACC_W:0] HALF = (ACC_W + 1)'(longint'(1) <<< (FRAC_SHIFT - 1));
        logic signed [ACC_W:0] biased;
        assign biased = ext + HALF;
        assign rnd    = biased >>> FRAC_SHIFT;
    end

    // Clamp the rescaled value into the signed output range and flag clamping.
    always_comb begin
        res = rnd[OUT_W-1:0];
        ovf = 1'b0;
        if (rnd > MAXV) begin
            res = OUT_W'(sat_max(OUT_W));
            ovf = 1'b1;
        end else if (rnd < MINV) begin
            res = OUT_W'(sat_min(OUT_W));
            ovf = 1'b1;
        end
    end

endmodule

// File: rtl/paramest_dense_acc.sv
// paramest_dense_acc: accumulates N_IN signed products per neuron, adds the
// bias, rescales/saturates and emits one result per neuron on a valid/ready
// stream. Optional ReLU after saturation: define PARAMEST_DENSE_ACC_RELU_EN.
module paramest_dense_acc
    import paramest_acc_pkg::*;
#(
    parameter int N_IN       = 16,
    parameter int PROD_W     = 29,
    parameter int BIAS_W     = 24,
    parameter int OUT_W      = 16,
    parameter int FRAC_SHIFT = 13
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    paramest_dense_acc_if.slave io
);
    localparam int ACC_W = acc_width(N_IN, PROD_W);
    localparam int CNT_W = $clog2(N_IN + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_IN - 1);

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] sum;
    logic [CNT_W-1:0]        cnt;
    logic                    rdy_q;
    logic                    accept;
    logic signed [OUT_W-1:0] rs_res;
    logic                    rs_ovf;
    logic signed [OUT_W-1:0] fin_res;
    logic                    fin_ovf;
    logic [OUT_W-1:0]        out_data_q;
    logic                    out_ovf_q;
    logic                    out_valid_q;

    // Registered ready is gated by reset so it reads 0 while reset is held.
    assign io.prod_ready = rdy_q & ap_rst_n;
    assign accept        = io.prod_valid & io.prod_ready;

    assign term     = io.prod_neg ? -ACC_W'(io.prod_data) : ACC_W'(io.prod_data);
    assign bias_ext = {{(ACC_W - BIAS_W){io.bias[BIAS_W-1]}}, io.bias};
    assign sum      = acc + bias_ext;

    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;
    assign io.out_ovf   = out_ovf_q;

    paramest_round_sat #(
        .ACC_W      (ACC_W),
        .OUT_W      (OUT_W),
        .FRAC_SHIFT (FRAC_SHIFT)
    ) u_round_sat (
        .sum (sum),
        .res (rs_res),
        .ovf (rs_ovf)
    );

    // Final output shaping: optional ReLU after saturation.
    always_comb begin
        fin_res = rs_res;
        fin_ovf = rs_ovf;
`ifdef PARAMEST_DENSE_ACC_RELU_EN
        if (rs_res[OUT_W-1]) begin
            fin_res = '0;
            fin_ovf = 1'b0;
        end
`endif
    end

    // Neuron FSM: accumulate products, add bias and register result, hold until taken.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            rdy_q       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc <= term;
                        cnt <= CNT_W'(1);
                        if (N_IN == 1) begin
                            state <= BIAS;
                            rdy_q <= 1'b0;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (accept) begin
                        acc <= acc + term;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state <= BIAS;
                            rdy_q <= 1'b0;
                        end
                    end
                end
                BIAS: begin
                    out_data_q  <= fin_res;
                    out_ovf_q   <= fin_ovf;
                    out_valid_q <= 1'b1;
                    state       <= OUT;
                end
                OUT: begin
                    if (io.out_ready) begin
                        out_valid_q <= 1'b0;
                        acc         <= '0;
                        cnt         <= '0;
                        rdy_q       <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_paramest_dense_acc.sv
// Directed testbench for paramest_dense_acc with N_IN=4, OUT_W=8, FRAC_SHIFT=2.
module tb_paramest_dense_acc;
    localparam int N_IN       = 4;
    localparam int PROD_W     = 29;
    localparam int BIAS_W     = 24;
    localparam int OUT_W      = 8;
    localparam int FRAC_SHIFT = 2;

    logic clk;
    logic rst_n;
    int   n_err;
    int   n_chk;

    paramest_dense_acc_if #(.PROD_W(PROD_W), .BIAS_W(BIAS_W), .OUT_W(OUT_W)) io ();

    paramest_dense_acc #(
        .N_IN       (N_IN),
        .PROD_W     (PROD_W),
        .BIAS_W     (BIAS_W),
        .OUT_W      (OUT_W),
        .FRAC_SHIFT (FRAC_SHIFT)
    ) dut (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .io       (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one product and wait (bounded) for its accept edge; returns #1 after that edge.
    task automatic send(input int v);
        bit ok;
        ok            = 1'b0;
        io.prod_neg   = (v < 0);
        io.prod_data  = PROD_W'((v < 0) ? -v : v);
        io.prod_valid = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (io.prod_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        io.prod_valid = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic neuron(input string tag, input int p[4], input int b, input int gap,
                          input int exp_d, input int exp_o);
        io.bias = BIAS_W'(b);
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
            end
            send(p[i]);
        end
        check({tag, "_lat0"}, int'(io.out_valid), 0);
        @(posedge clk);
        #1;
        check({tag, "_valid"}, int'(io.out_valid), 1);
        check({tag, "_data"}, int'($signed(io.out_data)), exp_d);
        check({tag, "_ovf"}, int'(io.out_ovf), exp_o);
        if (io.out_ready) begin
            @(posedge clk);
            #1;
            check({tag, "_done"}, int'(io.out_valid), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_err = 0;
        n_chk = 0;
        rst_n         = 1'b0;
        io.prod_valid = 1'b0;
        io.prod_data  = '0;
        io.prod_neg   = 1'b0;
        io.bias       = '0;
        io.out_ready  = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(io.out_valid), 0);
        check("rst_data", int'($signed(io.out_data)), 0);
        check("rst_ovf", int'(io.out_ovf), 0);
        @(negedge clk);
        check("rst_ready", int'(io.prod_ready), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", int'(io.prod_ready), 1);
        @(posedge clk);
        #1;

        // 100 -> (100+2)>>2 = 25
        neuron("basic", '{10, 20, 30, 40}, 0, 0, 25, 0);
        // 3 -> 5>>2 = 1; -3 -> -1>>>2 = -1; 2 -> 4>>2 = 1
        neuron("rnd_pos", '{1, 1, 1, 0}, 0, 0, 1, 0);
        neuron("rnd_neg", '{-1, -1, -1, 0}, 0, 0, -1, 0);
        neuron("rnd_half", '{2, 0, 0, 0}, 0, 0, 1, 0);
        // 4000 -> 1000 clamps high; -4000 -> -1000 clamps low; bias -4000 -> -1000 clamps low
        neuron("sat_hi", '{1000, 1000, 1000, 1000}, 0, 0, 127, 1);
        neuron("sat_lo", '{-1000, -1000, -1000, -1000}, 0, 0, -128, 1);
        neuron("sat_bias", '{0, 0, 0, 0}, -4000, 0, -128, 1);

        // Backpressure: 16+100 = 116 -> 118>>2 = 29, held while out_ready=0
        io.out_ready = 1'b0;
        neuron("bp", '{4, 4, 4, 4}, 100, 0, 29, 0);
        io.prod_valid = 1'b1;
        io.prod_neg   = 1'b0;
        io.prod_data  = PROD_W'(8);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", int'(io.out_valid), 1);
            check("bp_hold_data", int'($signed(io.out_data)), 29);
            check("bp_hold_ovf", int'(io.out_ovf), 0);
            check("bp_hold_ready", int'(io.prod_ready), 0);
        end
        io.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release", int'(io.out_valid), 0);
        check("bp_idle_ready", int'(io.prod_ready), 1);
        // Held 8 is accepted first: 32+100 = 132 -> 134>>2 = 33
        neuron("bp_next", '{8, 8, 8, 8}, 100, 0, 33, 0);

        // Bubbles between products give the same result as back-to-back
        neuron("bubble", '{10, 20, 30, 40}, 0, 2, 25, 0);

        // Reset mid-neuron discards the partial sum
        io.bias = '0;
        send(10);
        send(20);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", int'(io.prod_ready), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mid_rst_valid", int'(io.out_valid), 0);
        check("mid_rst_data", int'($signed(io.out_data)), 0);
        check("mid_rst_ovf", int'(io.out_ovf), 0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("mid_rst_noout", int'(io.out_valid), 0);
        end
        // 20 -> 22>>2 = 5
        neuron("post_rst", '{5, 5, 5, 5}, 0, 0, 5, 0);

        // -30 -> -28>>>2 = -7; ReLU clears it to 0
`ifdef PARAMEST_DENSE_ACC_RELU_EN
        neuron("relu_neg", '{-10, -20, 0, 0}, 0, 0, 0, 0);
`else
        neuron("relu_neg", '{-10, -20, 0, 0}, 0, 0, -7, 0);
`endif
        neuron("relu_sat", '{1000, 1000, 1000, 1000}, 0, 0, 127, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
